// File: rtl/sync_req_rx.sv
// Receive side of a four-phase request/ack crossing: filters the synchronized
// request, captures the sender payload, hands it to a valid/ready consumer and returns ack.
module sync_req_rx #(
  parameter int DW     = 8,
  parameter int TO_CYC = 1023
) (
  input  logic          rclk,
  input  logic          rst_l,
  input  logic          req_sync,
  input  logic [DW-1:0] data_async,
  input  logic          rdy,
  input  logic          err_clr,
  output logic          vld,
  output logic [DW-1:0] data_out,
  output logic          ack,
  output logic          err,
  output logic [15:0]   xfer_cnt
);

  // Counter only has to reach TO_CYC-1; keep at least one bit when disabled.
  localparam int            TW      = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'((TO_CYC == 0) ? 0 : TO_CYC - 1);
  localparam bit            TO_EN   = (TO_CYC != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            req_q_reg;
  logic            vld_reg, vld_next;
  logic            ack_reg, ack_next;
  logic            err_reg, err_next;
  logic            err_set;
  logic [DW-1:0]   data_reg, data_next;
  logic [15:0]     xfer_cnt_reg, xfer_cnt_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic            req_seen;

  // Two consecutive high samples are required before a request is believed.
  assign req_seen = req_sync && req_q_reg;

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_reg    <= IDLE;
      req_q_reg    <= 1'b0;
      vld_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      data_reg     <= '0;
      xfer_cnt_reg <= '0;
      to_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      req_q_reg    <= req_sync;
      vld_reg      <= vld_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      data_reg     <= data_next;
      xfer_cnt_reg <= xfer_cnt_next;
      to_cnt_reg   <= to_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    vld_next      = vld_reg;
    ack_next      = ack_reg;
    data_next     = data_reg;
    xfer_cnt_next = xfer_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    err_set       = 1'b0;

    case (state_reg)
      IDLE: begin
        vld_next = 1'b0;
        ack_next = 1'b0;
        if (req_seen) begin
          data_next  = data_async;
          vld_next   = 1'b1;
          state_next = VALID;
        end
      end

      VALID: begin
        if (rdy) begin
          // The consumer already took the data, so the transfer counts even
          // if the sender let go of the request in the same cycle.
          vld_next      = 1'b0;
          ack_next      = 1'b1;
          xfer_cnt_next = xfer_cnt_reg + 16'd1;
          to_cnt_next   = '0;
          state_next    = ACK;
          if (!req_sync) begin
            err_set = 1'b1;
          end
        end else if (!req_sync) begin
          err_set    = 1'b1;
          vld_next   = 1'b0;
          state_next = IDLE;
        end
      end

      ACK: begin
        if (!req_sync) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
          err_set    = 1'b1;
          ack_next   = 1'b0;
          state_next = DRAIN;
        end else if (TO_EN) begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      DRAIN: begin
        // Stale request must be released before a new capture is allowed.
        vld_next = 1'b0;
        ack_next = 1'b0;
        if (!req_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        vld_next   = 1'b0;
        ack_next   = 1'b0;
        state_next = IDLE;
      end
    endcase

    if (err_set) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  assign vld      = vld_reg;
  assign ack      = ack_reg;
  assign err      = err_reg;
  assign data_out = data_reg;
  assign xfer_cnt = xfer_cnt_reg;

endmodule

// File: tb/tb_sync_req_rx.sv
// Directed bench for sync_req_rx with a short timeout so the ACK watchdog is quick to reach.
module tb_sync_req_rx;

  logic        rclk = 1'b0;
  logic        rst_l;
  logic        req_sync;
  logic [7:0]  data_async;
  logic        rdy;
  logic        err_clr;
  logic        vld;
  logic [7:0]  data_out;
  logic        ack;
  logic        err;
  logic [15:0] xfer_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 rclk = ~rclk;

  sync_req_rx #(.DW(8), .TO_CYC(4)) dut (
    .rclk       (rclk),
    .rst_l      (rst_l),
    .req_sync   (req_sync),
    .data_async (data_async),
    .rdy        (rdy),
    .err_clr    (err_clr),
    .vld        (vld),
    .data_out   (data_out),
    .ack        (ack),
    .err        (err),
    .xfer_cnt   (xfer_cnt)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_sync   = 1'($urandom_range(0, 1));
      data_async = 8'($urandom_range(0, 255));
      rdy        = 1'($urandom_range(0, 1));
      err_clr    = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if ({vld, ack, err} !== 3'b000) begin
      $display("FAIL reset_flags: got vld/ack/err=%b want 000", {vld, ack, err});
      errors++;
    end
    checks++;
    if (data_out !== 8'h00) begin
      $display("FAIL reset_data: got %h want 00", data_out);
      errors++;
    end
    checks++;
    if (xfer_cnt !== 16'd0) begin
      $display("FAIL reset_cnt: got %0d want 0", xfer_cnt);
      errors++;
    end
    req_sync = 1'b0; data_async = 8'h00; rdy = 1'b0; err_clr = 1'b0;
    rst_l = 1'b1;
    tick();
    tick();
    $display("test_reset: vld=%b ack=%b err=%b cnt=%0d", vld, ack, err, xfer_cnt);
  endtask

  task automatic test_normal();
    req_sync = 1'b1; data_async = 8'hA5; rdy = 1'b1;
    tick();
    checks++;
    if (vld !== 1'b0) begin
      $display("FAIL normal_latency: got vld=%b want 0 one cycle after request", vld);
      errors++;
    end
    tick();
    checks++;
    if ({vld, ack} !== 2'b10) begin
      $display("FAIL normal_capture: got vld/ack=%b want 10", {vld, ack});
      errors++;
    end
    checks++;
    if (data_out !== 8'hA5) begin
      $display("FAIL normal_data: got %h want a5", data_out);
      errors++;
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({vld, ack, err} !== 3'b010) begin
      $display("FAIL normal_ack: got vld/ack/err=%b want 010", {vld, ack, err});
      errors++;
    end
    checks++;
    if (xfer_cnt !== exp_cnt) begin
      $display("FAIL normal_cnt: got %0d want %0d", xfer_cnt, exp_cnt);
      errors++;
    end
    req_sync = 1'b0; data_async = 8'h00;
    tick();
    checks++;
    if (ack !== 1'b0) begin
      $display("FAIL normal_ack_release: got ack=%b want 0", ack);
      errors++;
    end
    rdy = 1'b0;
    tick();
    $display("test_normal: data=%h cnt=%0d", data_out, xfer_cnt);
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [2];
    vec[0] = 8'h11;
    vec[1] = 8'h22;
    rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_sync = 1'b1; data_async = vec[i];
      tick();
      checks++;
      if (vld !== 1'b0) begin
        $display("FAIL b2b_early_%0d: got vld=%b want 0", i, vld);
        errors++;
      end
      tick();
      checks++;
      if ({vld, data_out} !== {1'b1, vec[i]}) begin
        $display("FAIL b2b_capture_%0d: got vld=%b data=%h want 1 %h", i, vld, data_out, vec[i]);
        errors++;
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if ({ack, xfer_cnt} !== {1'b1, exp_cnt}) begin
        $display("FAIL b2b_ack_%0d: got ack=%b cnt=%0d want 1 %0d", i, ack, xfer_cnt, exp_cnt);
        errors++;
      end
      req_sync = 1'b0;
      tick();
      checks++;
      if (ack !== 1'b0) begin
        $display("FAIL b2b_release_%0d: got ack=%b want 0", i, ack);
        errors++;
      end
      $display("test_back_to_back[%0d]: data=%h cnt=%0d", i, data_out, xfer_cnt);
    end
    rdy = 1'b0;
  endtask

  task automatic test_glitch();
    req_sync = 1'b1; data_async = 8'hEE;
    tick();
    req_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({vld, ack, err} !== 3'b000) begin
        $display("FAIL glitch_flags_%0d: got vld/ack/err=%b want 000", i, {vld, ack, err});
        errors++;
      end
    end
    checks++;
    if (xfer_cnt !== exp_cnt) begin
      $display("FAIL glitch_cnt: got %0d want %0d", xfer_cnt, exp_cnt);
      errors++;
    end
    $display("test_glitch: vld=%b err=%b cnt=%0d", vld, err, xfer_cnt);
  endtask

  task automatic test_backpressure_withdraw();
    req_sync = 1'b1; data_async = 8'h3C; rdy = 1'b0;
    tick();
    tick();
    data_async = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({vld, ack, data_out} !== {2'b10, 8'h3C}) begin
        $display("FAIL bp_hold_%0d: got vld=%b ack=%b data=%h want 1 0 3c", i, vld, ack, data_out);
        errors++;
      end
      tick();
    end
    req_sync = 1'b0;
    tick();
    checks++;
    if ({vld, ack, err} !== 3'b001) begin
      $display("FAIL withdraw_flags: got vld/ack/err=%b want 001", {vld, ack, err});
      errors++;
    end
    checks++;
    if (xfer_cnt !== exp_cnt) begin
      $display("FAIL withdraw_cnt: got %0d want %0d", xfer_cnt, exp_cnt);
      errors++;
    end
    tick();
    checks++;
    if ({ack, err} !== 2'b01) begin
      $display("FAIL withdraw_after: got ack/err=%b want 01", {ack, err});
      errors++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear: got err=%b want 0", err);
      errors++;
    end
    $display("test_backpressure_withdraw: err cleared, cnt=%0d", xfer_cnt);
  endtask

  task automatic test_accept_withdraw();
    req_sync = 1'b1; data_async = 8'h77; rdy = 1'b0;
    tick();
    tick();
    rdy = 1'b1; req_sync = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({vld, ack, err} !== 3'b011) begin
      $display("FAIL accwd_flags: got vld/ack/err=%b want 011", {vld, ack, err});
      errors++;
    end
    checks++;
    if ({xfer_cnt, data_out} !== {exp_cnt, 8'h77}) begin
      $display("FAIL accwd_cnt: got cnt=%0d data=%h want %0d 77", xfer_cnt, data_out, exp_cnt);
      errors++;
    end
    rdy = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0) begin
      $display("FAIL accwd_release: got ack=%b want 0", ack);
      errors++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("test_accept_withdraw: cnt=%0d", xfer_cnt);
  endtask

  task automatic test_timeout();
    req_sync = 1'b1; data_async = 8'h5A; rdy = 1'b1;
    tick();
    tick();
    tick();
    rdy = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ack, err} !== 2'b10) begin
        $display("FAIL to_ack_high_%0d: got ack/err=%b want 10", i, {ack, err});
        errors++;
      end
      if (i < 3) tick();
    end
    tick();
    checks++;
    if ({vld, ack, err} !== 3'b001) begin
      $display("FAIL to_expire: got vld/ack/err=%b want 001", {vld, ack, err});
      errors++;
    end
    checks++;
    if (xfer_cnt !== exp_cnt) begin
      $display("FAIL to_cnt: got %0d want %0d", xfer_cnt, exp_cnt);
      errors++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL to_err_clear: got err=%b want 0", err);
      errors++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({vld, ack} !== 2'b00) begin
        $display("FAIL to_drain_%0d: got vld/ack=%b want 00", i, {vld, ack});
        errors++;
      end
    end
    req_sync = 1'b0;
    tick();
    req_sync = 1'b1; data_async = 8'h6B;
    tick();
    checks++;
    if (vld !== 1'b0) begin
      $display("FAIL to_recapture_early: got vld=%b want 0", vld);
      errors++;
    end
    tick();
    checks++;
    if ({vld, data_out} !== {1'b1, 8'h6B}) begin
      $display("FAIL to_recapture: got vld=%b data=%h want 1 6b", vld, data_out);
      errors++;
    end
    req_sync = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if ({vld, err} !== 2'b01) begin
      $display("FAIL set_wins: got vld/err=%b want 01", {vld, err});
      errors++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("test_timeout: cnt=%0d", xfer_cnt);
  endtask

  task automatic test_reset_mid_ack();
    req_sync = 1'b1; data_async = 8'h99; rdy = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (ack !== 1'b1) begin
      $display("FAIL rst_ack_pre: got ack=%b want 1", ack);
      errors++;
    end
    rst_l = 1'b0;
    tick();
    exp_cnt = 16'd0;
    checks++;
    if ({vld, ack, err, data_out, xfer_cnt} !== {3'b000, 8'h00, 16'd0}) begin
      $display("FAIL rst_mid_ack: got vld=%b ack=%b err=%b data=%h cnt=%0d want all 0", vld, ack, err, data_out, xfer_cnt);
      errors++;
    end
    rst_l = 1'b1; rdy = 1'b0;
    tick();
    checks++;
    if (vld !== 1'b0) begin
      $display("FAIL rst_recapture_early: got vld=%b want 0", vld);
      errors++;
    end
    tick();
    checks++;
    if ({vld, data_out} !== {1'b1, 8'h99}) begin
      $display("FAIL rst_recapture: got vld=%b data=%h want 1 99", vld, data_out);
      errors++;
    end
    rdy = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({ack, xfer_cnt} !== {1'b1, exp_cnt}) begin
      $display("FAIL rst_recapture_ack: got ack=%b cnt=%0d want 1 %0d", ack, xfer_cnt, exp_cnt);
      errors++;
    end
    req_sync = 1'b0; rdy = 1'b0;
    tick();
    tick();
    $display("test_reset_mid_ack: cnt=%0d", xfer_cnt);
  endtask

  task automatic test_wrap();
    force dut.xfer_cnt_reg = 16'hFFFF;
    #1;
    release dut.xfer_cnt_reg;
    req_sync = 1'b1; data_async = 8'hE1; rdy = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({ack, xfer_cnt} !== {1'b1, 16'd0}) begin
      $display("FAIL wrap_cnt: got ack=%b cnt=%0d want 1 0", ack, xfer_cnt);
      errors++;
    end
    req_sync = 1'b0; rdy = 1'b0;
    tick();
    $display("test_wrap: cnt=%0d", xfer_cnt);
  endtask

  initial begin
    rst_l = 1'b0; req_sync = 1'b0; data_async = 8'h00; rdy = 1'b0; err_clr = 1'b0;
    test_reset();
    test_normal();
    test_back_to_back();
    test_glitch();
    test_backpressure_withdraw();
    test_accept_withdraw();
    test_timeout();
    test_reset_mid_ack();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
